// File: rtl/md_unit.sv
// Multiply/divide unit with private HI/LO for the E stage; fixed-latency mult/div plus mthi/mtlo.
// Optional madd/maddu accumulate is enabled by defining MD_MADD_EN.
module md_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  md_op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  typedef enum logic {IDLE, RUN} state_e;

  state_e      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [2:0]  op_q, op_d;
  logic [31:0] a_q, a_d, b_q, b_d;
  logic [31:0] hi_q, hi_d, lo_q, lo_d;

  logic        opSigned;
  logic [63:0] aExt, bExt, product;
  logic        negA, negB;
  logic [31:0] absA, absB, quoMag, remMag, quo, rem;

  assign opSigned = (op_q == 3'd0) || (op_q == 3'd2) || (op_q == 3'd6);

  // Sign/zero extension to 64 bits lets one unsigned multiplier serve both signednesses mod 2^64.
  assign aExt    = {{32{opSigned & a_q[31]}}, a_q};
  assign bExt    = {{32{opSigned & b_q[31]}}, b_q};
  assign product = aExt * bExt;

  // Signed divide on magnitudes; this also yields 0x80000000 / -1 = 0x80000000 rem 0 without overflow.
  assign negA   = opSigned & a_q[31];
  assign negB   = opSigned & b_q[31];
  assign absA   = negA ? (~a_q + 32'd1) : a_q;
  assign absB   = negB ? (~b_q + 32'd1) : b_q;
  assign quoMag = absA / absB;
  assign remMag = absA % absB;
  assign quo    = (negA ^ negB) ? (~quoMag + 32'd1) : quoMag;
  assign rem    = negA ? (~remMag + 32'd1) : remMag;

`ifdef MD_MADD_EN
  logic [63:0] accum;
  assign accum = {hi_q, lo_q} + product;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          case (md_op)
            3'd0, 3'd1: begin
              state_d = RUN;
              cnt_d   = 16'(MULT_CYCLES);
              op_d    = md_op;
              a_d     = A;
              b_d     = B;
            end
            3'd2, 3'd3: begin
              state_d = RUN;
              cnt_d   = 16'(DIV_CYCLES);
              op_d    = md_op;
              a_d     = A;
              b_d     = B;
            end
            3'd4: hi_d = A;
            3'd5: lo_d = A;
`ifdef MD_MADD_EN
            3'd6, 3'd7: begin
              state_d = RUN;
              cnt_d   = 16'(MULT_CYCLES);
              op_d    = md_op;
              a_d     = A;
              b_d     = B;
            end
`endif
            default: ;
          endcase
        end
      end
      RUN: begin
        // Requests arriving while running are dropped; the hazard unit is expected to stall them.
        if (cnt_q == 16'd1) begin
          state_d = IDLE;
          cnt_d   = '0;
          case (op_q)
            3'd0, 3'd1: {hi_d, lo_d} = product;
            3'd2, 3'd3: begin
              if (b_q != 32'd0) begin
                hi_d = rem;
                lo_d = quo;
              end
            end
`ifdef MD_MADD_EN
            3'd6, 3'd7: {hi_d, lo_d} = accum;
`endif
            default: ;
          endcase
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy = (state_q == RUN);
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_md_unit.sv
// Self-checking bench for md_unit: expected HI/LO values are queued at issue and popped on completion.
// Define MD_MADD_EN for both files to exercise the madd/maddu path.
module tb_md_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [2:0]  md_op = 3'd0;
  logic [31:0] A = 32'd0;
  logic [31:0] B = 32'd0;
  logic        busy;
  logic [31:0] hi, lo;

  int assertCount = 0;
  int failCount = 0;
  logic [63:0] expQ[$];

  md_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .reset(reset), .start(start), .md_op(md_op),
    .A(A), .B(B), .busy(busy), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  // Caller is at a negedge; start is seen by exactly one posedge, then we return at the next negedge.
  task automatic issueOp(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [63:0] expected);
    expQ.push_back(expected);
    start = 1'b1;
    md_op = op;
    A = a;
    B = b;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic waitIdle(output int cycles);
    cycles = 0;
    while (busy === 1'b1 && cycles < 100) begin
      @(negedge clk);
      cycles++;
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    assertCount++;
    if (busy !== 1'b0) begin failCount++; $display("[TB] FAIL reset_busy got %0b want 0", busy); end
    assertCount++;
    if (hi !== 32'd0) begin failCount++; $display("[TB] FAIL reset_hi got %h want 0", hi); end
    assertCount++;
    if (lo !== 32'd0) begin failCount++; $display("[TB] FAIL reset_lo got %h want 0", lo); end
  endtask

  task automatic test_mult;
    int cyc;
    logic [63:0] exp;
    issueOp(3'd0, 32'hFFFFFFFE, 32'd3, 64'hFFFFFFFF_FFFFFFFA);
    assertCount++;
    if (busy !== 1'b1) begin failCount++; $display("[TB] FAIL mult_busy_rise got %0b want 1", busy); end
    waitIdle(cyc);
    assertCount++;
    if (cyc != 5) begin failCount++; $display("[TB] FAIL mult_cycles got %0d want 5", cyc); end
    exp = expQ.pop_front();
    assertCount++;
    if ({hi, lo} !== exp) begin failCount++; $display("[TB] FAIL mult_result got %h want %h", {hi, lo}, exp); end
    issueOp(3'd1, 32'hFFFFFFFE, 32'd3, 64'h00000002_FFFFFFFA);
    waitIdle(cyc);
    exp = expQ.pop_front();
    assertCount++;
    if ({hi, lo} !== exp) begin failCount++; $display("[TB] FAIL multu_result got %h want %h", {hi, lo}, exp); end
  endtask

  task automatic test_back_to_back;
    int cyc;
    logic [63:0] exp;
    logic [31:0] opA[4] = '{32'd100, 32'hFFFFFFF9, 32'd7, 32'h80000000};
    logic [31:0] opB[4] = '{32'd7, 32'd2, 32'hFFFFFFFE, 32'hFFFFFFFF};
    logic [2:0]  ops[4] = '{3'd3, 3'd2, 3'd2, 3'd2};
    logic [63:0] res[4] = '{64'h00000002_0000000E, 64'hFFFFFFFF_FFFFFFFD,
                            64'h00000001_FFFFFFFD, 64'h00000000_80000000};
    for (int i = 0; i < 4; i++) begin
      issueOp(ops[i], opA[i], opB[i], res[i]);
      waitIdle(cyc);
      assertCount++;
      if (cyc != 10) begin failCount++; $display("[TB] FAIL div%0d_cycles got %0d want 10", i, cyc); end
      exp = expQ.pop_front();
      assertCount++;
      if ({hi, lo} !== exp) begin failCount++; $display("[TB] FAIL div%0d_result got %h want %h", i, {hi, lo}, exp); end
    end
  endtask

  task automatic test_div_zero;
    int cyc;
    logic [63:0] exp;
    issueOp(3'd4, 32'h11, 32'd0, 64'h00000011_00000000);
    exp = expQ.pop_front();
    assertCount++;
    if (hi !== exp[63:32]) begin failCount++; $display("[TB] FAIL mthi_visible got %h want %h", hi, exp[63:32]); end
    assertCount++;
    if (busy !== 1'b0) begin failCount++; $display("[TB] FAIL mthi_busy got %0b want 0", busy); end
    issueOp(3'd5, 32'h22, 32'd0, 64'h00000011_00000022);
    exp = expQ.pop_front();
    assertCount++;
    if ({hi, lo} !== exp) begin failCount++; $display("[TB] FAIL mtlo_visible got %h want %h", {hi, lo}, exp); end
    issueOp(3'd2, 32'd5, 32'd0, 64'h00000011_00000022);
    waitIdle(cyc);
    assertCount++;
    if (cyc != 10) begin failCount++; $display("[TB] FAIL divzero_cycles got %0d want 10", cyc); end
    exp = expQ.pop_front();
    assertCount++;
    if ({hi, lo} !== exp) begin failCount++; $display("[TB] FAIL divzero_result got %h want %h", {hi, lo}, exp); end
  endtask

  task automatic test_ignore_during_run;
    int cyc;
    logic [63:0] exp;
    issueOp(3'd0, 32'd5, 32'd7, 64'h00000000_00000023);
    @(negedge clk);
    start = 1'b1;
    md_op = 3'd5;
    A = 32'h55;
    @(negedge clk);
    start = 1'b0;
    md_op = 3'd2;
    A = 32'd100;
    B = 32'd100;
    assertCount++;
    if (lo !== 32'h22) begin failCount++; $display("[TB] FAIL mtlo_ignored got %h want 22", lo); end
    waitIdle(cyc);
    assertCount++;
    if (cyc != 3) begin failCount++; $display("[TB] FAIL ignore_cycles got %0d want 3", cyc); end
    exp = expQ.pop_front();
    assertCount++;
    if ({hi, lo} !== exp) begin failCount++; $display("[TB] FAIL latched_result got %h want %h", {hi, lo}, exp); end
  endtask

  task automatic test_reset_abort;
    int busySeen;
    issueOp(3'd2, 32'd100, 32'd7, 64'h0);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    assertCount++;
    if ({busy, hi, lo} !== 65'd0) begin
      failCount++;
      $display("[TB] FAIL abort_state got busy=%0b hi=%h lo=%h want all 0", busy, hi, lo);
    end
    busySeen = 0;
    repeat (15) begin
      @(negedge clk);
      if (busy === 1'b1) busySeen++;
    end
    void'(expQ.pop_front());
    assertCount++;
    if ({hi, lo} !== 64'd0 || busySeen != 0) begin
      failCount++;
      $display("[TB] FAIL abort_no_commit got hi=%h lo=%h busyCycles=%0d want 0", hi, lo, busySeen);
    end
  endtask

  task automatic test_madd;
    int cyc;
    logic [63:0] exp;
    issueOp(3'd5, 32'hFFFFFFFF, 32'd0, 64'h00000000_FFFFFFFF);
    exp = expQ.pop_front();
    assertCount++;
    if ({hi, lo} !== exp) begin failCount++; $display("[TB] FAIL madd_preset got %h want %h", {hi, lo}, exp); end
`ifdef MD_MADD_EN
    issueOp(3'd7, 32'd1, 32'd1, 64'h00000001_00000000);
    assertCount++;
    if (busy !== 1'b1) begin failCount++; $display("[TB] FAIL maddu_busy got %0b want 1", busy); end
    waitIdle(cyc);
    assertCount++;
    if (cyc != 5) begin failCount++; $display("[TB] FAIL maddu_cycles got %0d want 5", cyc); end
`else
    issueOp(3'd7, 32'd1, 32'd1, 64'h00000000_FFFFFFFF);
    cyc = (busy === 1'b1) ? 1 : 0;
    repeat (10) begin
      @(negedge clk);
      if (busy === 1'b1) cyc++;
    end
    assertCount++;
    if (cyc != 0) begin failCount++; $display("[TB] FAIL maddu_noop_busy got %0d busy cycles want 0", cyc); end
`endif
    exp = expQ.pop_front();
    assertCount++;
    if ({hi, lo} !== exp) begin failCount++; $display("[TB] FAIL maddu_result got %h want %h", {hi, lo}, exp); end
  endtask

  initial begin
    test_reset;
    test_mult;
    test_back_to_back;
    test_div_zero;
    test_ignore_during_run;
    test_reset_abort;
    test_madd;
    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
